// File: rtl/cmd_cntrl.sv
// Command controller for a line-following cart. It accepts GO/STOP command
// bytes, tracks the destination station, compares station IDs from the
// barcode decoder, and drives the motion enable plus a piezo buzzer that
// sounds while the cart is in transit but blocked by an obstacle.
module cmd_cntrl #(
  parameter int BUZZ_HALF = 6250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd,
  input  logic       cmd_rdy,
  output logic       clr_cmd_rdy,
  input  logic [7:0] ID,
  input  logic       ID_vld,
  output logic       clr_ID_vld,
  input  logic       OK2Move,
  output logic       go,
  output logic       buzz,
  output logic       buzz_n,
  output logic       in_transit
);

  // A one-cycle half period would give a zero-width counter; keep at least one bit.
  localparam int CW = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUZZ_HALF - 1);

  typedef enum logic {
    IDLE       = 1'b0,
    IN_TRANSIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_STOP = 2'b00,
    OP_GO   = 2'b01
  } opcode_t;

  state_t        state;
  logic [5:0]    dest_id;
  logic [CW-1:0] buzz_cnt;
  logic          buzz_en;
  logic          id_match;
  logic [1:0]    opcode;

  assign opcode     = cmd[7:6];
  assign id_match   = (ID[5:0] == dest_id);
  assign in_transit = (state == IN_TRANSIT);
  assign go         = in_transit & OK2Move;
  assign buzz_en    = in_transit & ~OK2Move;
  assign buzz_n     = ~buzz;

  // Mealy acknowledges; a pending command takes priority over an ID while in transit.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    clr_cmd_rdy = 1'b0;
    clr_ID_vld  = 1'b0;
    if (rst_n) begin
      clr_cmd_rdy = cmd_rdy;
      if (state == IDLE) clr_ID_vld = ID_vld;
      else               clr_ID_vld = ID_vld & ~cmd_rdy;
    end
  end

  // Transit state and destination register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dest_id <= 6'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (cmd_rdy && opcode == OP_GO) begin
            dest_id <= cmd[5:0];
            state   <= IN_TRANSIT;
          end
        end
        IN_TRANSIT: begin
          if (cmd_rdy) begin
            if (opcode == OP_GO)        dest_id <= cmd[5:0];
            else if (opcode == OP_STOP) state   <= IDLE;
          end else if (ID_vld && id_match) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buzzer half-period counter; held cleared whenever the buzzer is silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buzz_cnt <= '0;
      buzz     <= 1'b0;
    end else if (!buzz_en) begin
      buzz_cnt <= '0;
      buzz     <= 1'b0;
    end else if (buzz_cnt == CNT_LAST) begin
      buzz_cnt <= '0;
      buzz     <= ~buzz;
    end else begin
      buzz_cnt <= buzz_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_cntrl.sv
// Directed bench for cmd_cntrl. Inputs change on the falling edge; Mealy
// acknowledges are sampled 1 ns later and registered state 1 ns after the
// following rising edge.
module tb_cmd_cntrl;

  localparam int BH = 6250;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       clr_cmd_rdy;
  logic [7:0] ID;
  logic       ID_vld;
  logic       clr_ID_vld;
  logic       OK2Move;
  logic       go;
  logic       buzz;
  logic       buzz_n;
  logic       in_transit;

  int tests_run    = 0;
  int tests_failed = 0;

  cmd_cntrl #(.BUZZ_HALF(BH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .ID(ID), .ID_vld(ID_vld),
    .clr_ID_vld(clr_ID_vld), .OK2Move(OK2Move), .go(go), .buzz(buzz),
    .buzz_n(buzz_n), .in_transit(in_transit)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive at the falling edge, then let combinational outputs settle.
  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  // Put the block in transit to a destination without checking (setup only).
  task automatic start_go(input logic [5:0] dest);
    @(negedge clk);
    cmd = {2'b01, dest}; cmd_rdy = 1'b1;
    tick();
    @(negedge clk);
    cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd = 8'h45; cmd_rdy = 1'b1; ID = 8'h00; ID_vld = 1'b1; OK2Move = 1'b1;
    tick(); tick();
    tests_run++; if (clr_cmd_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_clr_cmd: got %b want 0", clr_cmd_rdy); end
    tests_run++; if (clr_ID_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_clr_id: got %b want 0", clr_ID_vld); end
    tests_run++; if ({in_transit, go} !== 2'b00) begin tests_failed++; $display("FAIL reset_transit_go: got %b want 00", {in_transit, go}); end
    tests_run++; if ({buzz, buzz_n} !== 2'b01) begin tests_failed++; $display("FAIL reset_buzz: got %b want 01", {buzz, buzz_n}); end
    @(negedge clk);
    cmd_rdy = 1'b0; ID_vld = 1'b0;
    rst_n = 1'b1;
    tick();
    tests_run++; if (in_transit !== 1'b0) begin tests_failed++; $display("FAIL reset_release: in_transit got %b want 0", in_transit); end
  endtask

  task automatic test_go();
    @(negedge clk);
    OK2Move = 1'b1; cmd = 8'h45; cmd_rdy = 1'b1; #1;
    tests_run++; if ({clr_cmd_rdy, in_transit} !== 2'b10) begin tests_failed++; $display("FAIL go_ack: {clr,in_transit} got %b want 10", {clr_cmd_rdy, in_transit}); end
    tick();
    tests_run++; if ({in_transit, go} !== 2'b11) begin tests_failed++; $display("FAIL go_transit: {in_transit,go} got %b want 11", {in_transit, go}); end
    @(negedge clk); cmd_rdy = 1'b0; #1;
    tests_run++; if (clr_cmd_rdy !== 1'b0) begin tests_failed++; $display("FAIL go_ack_len: got %b want 0", clr_cmd_rdy); end
  endtask

  task automatic test_id_match();
    @(negedge clk);
    ID = 8'h03; ID_vld = 1'b1; #1;
    tests_run++; if (clr_ID_vld !== 1'b1) begin tests_failed++; $display("FAIL id_miss_ack: got %b want 1", clr_ID_vld); end
    tick();
    tests_run++; if (in_transit !== 1'b1) begin tests_failed++; $display("FAIL id_miss_stay: in_transit got %b want 1", in_transit); end
    @(negedge clk);
    ID = 8'h05; #1;
    tests_run++; if (clr_ID_vld !== 1'b1) begin tests_failed++; $display("FAIL id_hit_ack: got %b want 1", clr_ID_vld); end
    tick();
    tests_run++; if ({in_transit, go} !== 2'b00) begin tests_failed++; $display("FAIL id_hit_stop: {in_transit,go} got %b want 00", {in_transit, go}); end
    @(negedge clk); ID_vld = 1'b0;
  endtask

  task automatic test_buzz();
    start_go(6'h05);
    OK2Move = 1'b0; #1;
    tests_run++; if (go !== 1'b0) begin tests_failed++; $display("FAIL buzz_go_low: got %b want 0", go); end
    for (int n = 1; n <= 3 * BH; n++) begin
      tick();
      if (n == BH - 1 || n == BH || n == 2 * BH - 1 || n == 2 * BH || n == 3 * BH) begin
        // Buzz toggles on every BH-th blocked edge, starting from 0.
        logic exp_buzz;
        exp_buzz = ((n / BH) % 2) == 1;
        tests_run++;
        if ({buzz, buzz_n} !== {exp_buzz, ~exp_buzz}) begin
          tests_failed++;
          $display("FAIL buzz_edge_%0d: {buzz,buzz_n} got %b want %b", n, {buzz, buzz_n}, {exp_buzz, ~exp_buzz});
        end
      end
    end
    @(negedge clk);
    OK2Move = 1'b1; #1;
    tests_run++; if (go !== 1'b1) begin tests_failed++; $display("FAIL buzz_go_resume: got %b want 1", go); end
    tick();
    tests_run++; if ({buzz, buzz_n} !== 2'b01) begin tests_failed++; $display("FAIL buzz_silence: got %b want 01", {buzz, buzz_n}); end
  endtask

  task automatic test_simultaneous();
    // Still in transit to 6'h05 from the buzz test.
    @(negedge clk);
    cmd = 8'h00; cmd_rdy = 1'b1; ID = 8'h05; ID_vld = 1'b1; #1;
    tests_run++; if ({clr_cmd_rdy, clr_ID_vld} !== 2'b10) begin tests_failed++; $display("FAIL sim_transit_ack: got %b want 10", {clr_cmd_rdy, clr_ID_vld}); end
    tick();
    tests_run++; if (in_transit !== 1'b0) begin tests_failed++; $display("FAIL sim_stop: in_transit got %b want 0", in_transit); end
    @(negedge clk);
    cmd_rdy = 1'b0; #1;
    tests_run++; if ({clr_cmd_rdy, clr_ID_vld} !== 2'b01) begin tests_failed++; $display("FAIL sim_late_id_ack: got %b want 01", {clr_cmd_rdy, clr_ID_vld}); end
    tick();
    tests_run++; if (in_transit !== 1'b0) begin tests_failed++; $display("FAIL sim_idle_stay: in_transit got %b want 0", in_transit); end
    // Both pending in IDLE: both acknowledged together.
    @(negedge clk);
    cmd = 8'hC5; cmd_rdy = 1'b1; ID = 8'h07; ID_vld = 1'b1; #1;
    tests_run++; if ({clr_cmd_rdy, clr_ID_vld} !== 2'b11) begin tests_failed++; $display("FAIL sim_idle_ack: got %b want 11", {clr_cmd_rdy, clr_ID_vld}); end
    @(negedge clk);
    cmd_rdy = 1'b0; ID_vld = 1'b0;
  endtask

  task automatic test_retarget();
    start_go(6'h05);
    cmd = 8'h4A; cmd_rdy = 1'b1; #1;
    tests_run++; if (clr_cmd_rdy !== 1'b1) begin tests_failed++; $display("FAIL retarget_ack: got %b want 1", clr_cmd_rdy); end
    tick();
    @(negedge clk);
    cmd_rdy = 1'b0; ID = 8'h05; ID_vld = 1'b1;
    tick();
    tests_run++; if (in_transit !== 1'b1) begin tests_failed++; $display("FAIL retarget_old_id: in_transit got %b want 1", in_transit); end
    // Ignored opcode in transit must leave the destination alone.
    @(negedge clk);
    ID_vld = 1'b0; cmd = 8'h85; cmd_rdy = 1'b1; #1;
    tests_run++; if (clr_cmd_rdy !== 1'b1) begin tests_failed++; $display("FAIL ignored_transit_ack: got %b want 1", clr_cmd_rdy); end
    tick();
    @(negedge clk);
    cmd_rdy = 1'b0; ID = 8'h05; ID_vld = 1'b1;
    tick();
    tests_run++; if (in_transit !== 1'b1) begin tests_failed++; $display("FAIL ignored_keeps_dest: in_transit got %b want 1", in_transit); end
    // Upper ID bits are not part of the match.
    @(negedge clk);
    ID = 8'h8A;
    tick();
    tests_run++; if (in_transit !== 1'b0) begin tests_failed++; $display("FAIL retarget_new_id: in_transit got %b want 0", in_transit); end
    @(negedge clk); ID_vld = 1'b0;
  endtask

  task automatic test_ignored_and_reset();
    at_neg();
    cmd = 8'hC5; cmd_rdy = 1'b1; #1;
    tests_run++; if (clr_cmd_rdy !== 1'b1) begin tests_failed++; $display("FAIL ignored_idle_ack: got %b want 1", clr_cmd_rdy); end
    tick();
    tests_run++; if (in_transit !== 1'b0) begin tests_failed++; $display("FAIL ignored_idle_stay: in_transit got %b want 0", in_transit); end
    @(negedge clk); cmd_rdy = 1'b0;
    start_go(6'h11);
    OK2Move = 1'b0;
    repeat (BH) tick();
    tests_run++; if ({in_transit, buzz} !== 2'b11) begin tests_failed++; $display("FAIL areset_setup: {in_transit,buzz} got %b want 11", {in_transit, buzz}); end
    // Assert reset mid-cycle, away from any clock edge.
    @(negedge clk); #2;
    OK2Move = 1'b1; #1;
    rst_n = 1'b0; #1;
    tests_run++; if ({go, in_transit, buzz, buzz_n} !== 4'b0001) begin tests_failed++; $display("FAIL areset_clear: {go,in_transit,buzz,buzz_n} got %b want 0001", {go, in_transit, buzz, buzz_n}); end
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    tests_run++; if ({go, in_transit} !== 2'b00) begin tests_failed++; $display("FAIL areset_no_pending: {go,in_transit} got %b want 00", {go, in_transit}); end
  endtask

  initial begin
    test_reset();
    test_go();
    test_id_match();
    test_buzz();
    test_simultaneous();
    test_retarget();
    test_ignored_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cmd_cntrl.md
CMD_CNTRL -- requirements
Module: cmd_cntrl

Interface
REQ-001 Parameter BUZZ_HALF, default 6250, is the buzz half-period in clk cycles (4 kHz at 50 MHz).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd  input  8  command byte: [7:6] opcode, [5:0] destination station ID.
REQ-005 cmd_rdy  input  1  command valid; held high by the source until clr_cmd_rdy is seen.
REQ-006 clr_cmd_rdy  output  1  one-cycle pulse acknowledging consumption of cmd.
REQ-007 ID  input  8  station ID from the barcode decoder; only [5:0] is compared.
REQ-008 ID_vld  input  1  barcode decoder holds ID valid until clr_ID_vld.
REQ-009 clr_ID_vld  output  1  one-cycle pulse acknowledging consumption of ID.
REQ-010 OK2Move  input  1  obstacle-free indication from the proximity logic.
REQ-011 go  output  1  motion enable to the motor/PID path.
REQ-012 buzz, buzz_n  output  1 each  complementary piezo drive.
REQ-013 in_transit  output  1  high while a destination is active.

Function
REQ-014 Opcodes: 2'b01 = GO (latch cmd[5:0] as dest_ID); 2'b00 = STOP; 2'b10/2'b11 = ignored, but still acknowledged.
REQ-015 FSM has two states, IDLE and IN_TRANSIT, held in a register; in_transit = (state == IN_TRANSIT).
REQ-016 clr_cmd_rdy and clr_ID_vld are Mealy outputs: high in the same cycle the qualifying input is sampled high in the state that consumes it.
REQ-017 IDLE, cmd_rdy=1: pulse clr_cmd_rdy; on GO, load dest_ID and go to IN_TRANSIT at the next edge; on STOP or ignored opcode, stay in IDLE.
REQ-018 IDLE, ID_vld=1: pulse clr_ID_vld and discard the ID; stay in IDLE.
REQ-019 IN_TRANSIT, cmd_rdy=1: pulse clr_cmd_rdy; on GO, reload dest_ID and stay; on STOP, go to IDLE; on ignored opcode, stay.
REQ-020 IN_TRANSIT, ID_vld=1 and cmd_rdy=0: pulse clr_ID_vld; if ID[5:0]==dest_ID, go to IDLE; otherwise stay.
REQ-021 Simultaneous cmd_rdy and ID_vld in IN_TRANSIT: the command is handled and clr_ID_vld stays low, so ID_vld is handled in a later cycle against the updated dest_ID.
REQ-022 Simultaneous cmd_rdy and ID_vld in IDLE: both are acknowledged in the same cycle.
REQ-023 Station match uses the 6-bit equality ID[5:0]==dest_ID; ID[7:6] is ignored.
REQ-024 go = in_transit & OK2Move (combinational, no added latency).
REQ-025 Buzz enable = in_transit & ~OK2Move.
REQ-026 Buzz counter: width ceil(log2(BUZZ_HALF)) bits.
  - While buzz is enabled, it counts up.
  - On reaching BUZZ_HALF-1 it wraps to 0 and toggles buzz.
REQ-027 Buzz disabled: counter is held at 0, buzz=0, buzz_n=1.
REQ-028 buzz_n = ~buzz at all times, including reset.
REQ-029 dest_ID changes only on an acknowledged GO.

Reset
REQ-030 On rst_n low, asynchronously:
  - state=IDLE, dest_ID=0, buzz counter=0, buzz=0, buzz_n=1.
  - Hence go=0, in_transit=0.
REQ-031 clr_cmd_rdy and clr_ID_vld are 0 while rst_n is low.
REQ-032 Reset asserted mid-transit returns the block to IDLE; no command is pending after release.

Verification
REQ-033 Reset, then cmd=8'h45 with cmd_rdy for 1 cycle, OK2Move=1:
  - clr_cmd_rdy pulses 1 cycle.
  - in_transit and go go high on the next edge.
REQ-034 In transit to 6'h05, ID_vld with ID=8'h03:
  - clr_ID_vld pulses; in_transit stays 1.
  - Then ID=8'h05: clr_ID_vld pulses, and in_transit and go drop at the next edge.
REQ-035 In transit, OK2Move=0 for 3*BUZZ_HALF cycles:
  - go=0.
  - buzz toggles every 6250 cycles, with buzz_n its complement.
  - On OK2Move=1, go=1, buzz=0, buzz_n=1.
REQ-036 In transit, cmd=8'h00 (STOP) and ID_vld with a matching ID in the same cycle:
  - only clr_cmd_rdy pulses; the block goes to IDLE.
  - The following cycle clr_ID_vld pulses and the block stays in IDLE.
REQ-037 In transit to 6'h05, cmd=8'h4A (GO to 6'h0A) then ID=8'h05: the block stays in transit; a later ID=8'h0A ends transit.
REQ-038 cmd=8'hC5 in IDLE: clr_cmd_rdy pulses; in_transit stays 0.
  - Then assert rst_n low during transit: go, in_transit and buzz clear immediately (asynchronously).
